// File: rtl/gshare_index_unit_if.sv
// rtl/gshare_index_unit_if.sv - fetch/resolve bundle for the gshare index unit
//
// Purpose: groups the fetch-side lookup and resolve-side update signals.
// Ports (signals):
//   fetch_valid, fetch_is_branch, fetch_pc, pred_taken   fetch side, into unit
//   addr, full                                           fetch side, from unit
//   resolve_valid, resolve_taken, resolve_mispredict     resolve side, into unit
//   past, taken2, upd_valid, resolve_err                 update side, from unit
// Modports: master drives the unit (fetch/resolve logic), slave is the unit.
interface gshare_index_unit_if #(
  parameter int HIST_W = 12
);
  logic              fetch_valid;
  logic              fetch_is_branch;
  logic [31:0]       fetch_pc;
  logic              pred_taken;
  logic [HIST_W-1:0] addr;
  logic              full;
  logic              resolve_valid;
  logic              resolve_taken;
  logic              resolve_mispredict;
  logic [HIST_W-1:0] past;
  logic              taken2;
  logic              upd_valid;
  logic              resolve_err;

  modport master (
    output fetch_valid, fetch_is_branch, fetch_pc, pred_taken,
    output resolve_valid, resolve_taken, resolve_mispredict,
    input  addr, full, past, taken2, upd_valid, resolve_err
  );

  modport slave (
    input  fetch_valid, fetch_is_branch, fetch_pc, pred_taken,
    input  resolve_valid, resolve_taken, resolve_mispredict,
    output addr, full, past, taken2, upd_valid, resolve_err
  );
endinterface

// File: rtl/gshare_index_unit.sv
// rtl/gshare_index_unit.sv - gshare index generator with in-flight branch queue
//
// Purpose: forms the pattern-table index as PC XOR speculative global history,
// remembers the index of every in-flight conditional branch, and hands it back
// with the real outcome when that branch resolves. A mispredict rebuilds the
// speculative history from the architectural one and drops all younger entries.
// Ports:
//   clk   in  clock, all state on rising edge
//   rst   in  synchronous active-high reset
//   bus   slave modport of gshare_index_unit_if (fetch, resolve, update signals)
module gshare_index_unit #(
  parameter int HIST_W = 12,
  parameter int DEPTH  = 4
) (
  input logic             clk,
  input logic             rst,
  gshare_index_unit_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);

  logic [HIST_W-1:0] r_spec_ghr;
  logic [HIST_W-1:0] r_arch_ghr;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W:0]    r_count;
  logic [HIST_W-1:0] r_queue [DEPTH];
  logic [HIST_W-1:0] r_past;
  logic              r_taken2;
  logic              r_upd_valid;
  logic              r_resolve_err;

  logic [HIST_W-1:0] w_addr;
  logic              w_full;
  logic              w_pop;
  logic              w_flush;
  logic              w_push;
  logic [PTR_W:0]    w_count_nxt;
  logic              w_unused_bits;

  assign w_addr = bus.fetch_pc[HIST_W+1:2] ^ r_spec_ghr;
  assign w_full = (r_count == FULL_CNT);

  // A pop frees a slot on the same edge, so a push alongside a resolve is
  // accepted even when full. A mispredict squashes the same-cycle push.
  assign w_pop   = bus.resolve_valid & (r_count != '0);
  assign w_flush = w_pop & bus.resolve_mispredict;
  assign w_push  = bus.fetch_valid & bus.fetch_is_branch & (~w_full | w_pop) & ~w_flush;

  always_comb begin
    w_count_nxt = r_count;
    if (w_flush) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_ONE;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_spec_ghr    <= '0;
      r_arch_ghr    <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_past        <= '0;
      r_taken2      <= 1'b0;
      r_upd_valid   <= 1'b0;
      r_resolve_err <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      r_upd_valid <= w_pop;
      if (w_push) begin
        r_tail <= r_tail + PTR_ONE;
      end
      if (w_flush) begin
        // Tail is untouched because the same-cycle push was squashed.
        r_head <= r_tail;
      end else if (w_pop) begin
        r_head <= r_head + PTR_ONE;
      end
      if (w_pop) begin
        r_past     <= r_queue[r_head];
        r_taken2   <= bus.resolve_taken;
        r_arch_ghr <= {r_arch_ghr[HIST_W-2:0], bus.resolve_taken};
      end
      if (w_flush) begin
        r_spec_ghr <= {r_arch_ghr[HIST_W-2:0], bus.resolve_taken};
      end else if (w_push) begin
        r_spec_ghr <= {r_spec_ghr[HIST_W-2:0], bus.pred_taken};
      end
      if (bus.resolve_valid && (r_count == '0)) begin
        r_resolve_err <= 1'b1;
      end
    end
  end

  // Queue storage needs no reset: count/pointers define which slots are live.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_queue[r_tail] <= w_addr;
    end
  end

  assign w_unused_bits = ^{bus.fetch_pc[31:HIST_W+2], bus.fetch_pc[1:0], r_arch_ghr[HIST_W-1]};

  assign bus.addr        = w_addr;
  assign bus.full        = w_full;
  assign bus.past        = r_past;
  assign bus.taken2      = r_taken2;
  assign bus.upd_valid   = r_upd_valid;
  assign bus.resolve_err = r_resolve_err;
endmodule

// File: tb/tb_gshare_index_unit.sv
// tb/tb_gshare_index_unit.sv - directed self-checking bench for gshare_index_unit
module tb_gshare_index_unit;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  gshare_index_unit_if #(.HIST_W(12)) bus ();

  gshare_index_unit #(.HIST_W(12), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_fetch(input logic v, input logic br, input logic [31:0] pc, input logic pt);
    bus.fetch_valid     = v;
    bus.fetch_is_branch = br;
    bus.fetch_pc        = pc;
    bus.pred_taken      = pt;
  endtask

  task automatic set_res(input logic v, input logic t, input logic m);
    bus.resolve_valid      = v;
    bus.resolve_taken      = t;
    bus.resolve_mispredict = m;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_fetch(1'b0, 1'b0, 32'h0, 1'b0);
    set_res(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] full_pc   [4];
    logic        full_pred [4];
    logic [31:0] full_addr [4];
    logic        drain_t   [4];
    logic [31:0] drain_past[4];

    n_checks = 0;
    n_fail   = 0;
    full_pc    = '{32'h100, 32'h200, 32'h300, 32'h400};
    full_pred  = '{1'b1, 1'b1, 1'b0, 1'b1};
    full_addr  = '{32'h040, 32'h081, 32'h0C3, 32'h106};
    drain_t    = '{1'b0, 1'b1, 1'b1, 1'b0};
    drain_past = '{32'h081, 32'h0C3, 32'h106, 32'h14D};

    // Reset state
    do_reset();
    set_fetch(1'b0, 1'b0, 32'h0000_1234, 1'b0);
    #1;
    chk("rst_addr", 32'(bus.addr), 32'h48D);
    chk("rst_full", 32'(bus.full), 32'h0);
    chk("rst_upd", 32'(bus.upd_valid), 32'h0);
    chk("rst_past", 32'(bus.past), 32'h0);
    chk("rst_taken2", 32'(bus.taken2), 32'h0);
    chk("rst_err", 32'(bus.resolve_err), 32'h0);

    // Two pushes at the same PC, then resolve both in order
    set_fetch(1'b1, 1'b1, 32'h1234, 1'b1);
    #1 chk("push1_addr", 32'(bus.addr), 32'h48D);
    tick();
    set_fetch(1'b1, 1'b1, 32'h1234, 1'b0);
    #1 chk("push2_addr", 32'(bus.addr), 32'h48C);
    tick();
    set_fetch(1'b0, 1'b0, 32'h1234, 1'b0);
    set_res(1'b1, 1'b1, 1'b0);
    tick();
    chk("res1_upd", 32'(bus.upd_valid), 32'h1);
    chk("res1_past", 32'(bus.past), 32'h48D);
    chk("res1_taken2", 32'(bus.taken2), 32'h1);
    set_res(1'b0, 1'b0, 1'b0);
    tick();
    chk("res1_pulse_end", 32'(bus.upd_valid), 32'h0);
    set_res(1'b1, 1'b0, 1'b0);
    tick();
    chk("res2_upd", 32'(bus.upd_valid), 32'h1);
    chk("res2_past", 32'(bus.past), 32'h48C);
    chk("res2_taken2", 32'(bus.taken2), 32'h0);
    set_res(1'b0, 1'b0, 1'b0);
    tick();
    chk("res2_pulse_end", 32'(bus.upd_valid), 32'h0);
    chk("res2_no_err", 32'(bus.resolve_err), 32'h0);

    // Fill to full, ignored push, resolve+push while full, drain across wrap
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_fetch(1'b1, 1'b1, full_pc[i], full_pred[i]);
      #1 chk($sformatf("fill_addr%0d", i), 32'(bus.addr), full_addr[i]);
      tick();
    end
    chk("fill_full", 32'(bus.full), 32'h1);
    set_fetch(1'b1, 1'b1, 32'h500, 1'b1);
    #1 chk("over_addr", 32'(bus.addr), 32'h14D);
    tick();
    chk("over_hist_kept", 32'(bus.addr), 32'h14D);
    chk("over_full", 32'(bus.full), 32'h1);
    set_fetch(1'b1, 1'b1, 32'h500, 1'b0);
    set_res(1'b1, 1'b1, 1'b0);
    tick();
    chk("swap_past", 32'(bus.past), 32'h040);
    chk("swap_upd", 32'(bus.upd_valid), 32'h1);
    chk("swap_full", 32'(bus.full), 32'h1);
    set_fetch(1'b0, 1'b0, 32'h500, 1'b0);
    for (int i = 0; i < 4; i++) begin
      set_res(1'b1, drain_t[i], 1'b0);
      tick();
      chk($sformatf("drain_past%0d", i), 32'(bus.past), drain_past[i]);
      chk($sformatf("drain_upd%0d", i), 32'(bus.upd_valid), 32'h1);
      chk($sformatf("drain_taken2_%0d", i), 32'(bus.taken2), 32'(drain_t[i]));
      if (i == 0) chk("drain_not_full", 32'(bus.full), 32'h0);
    end
    set_res(1'b0, 1'b0, 1'b0);
    tick();
    chk("drain_pulse_end", 32'(bus.upd_valid), 32'h0);
    chk("drain_addr", 32'(bus.addr), 32'h15A);

    // Mispredict repair with concurrent push, then empty resolve
    do_reset();
    set_fetch(1'b1, 1'b1, 32'h0, 1'b1);
    tick();
    set_fetch(1'b1, 1'b1, 32'h0, 1'b0);
    tick();
    set_fetch(1'b1, 1'b1, 32'h0, 1'b1);
    tick();
    set_fetch(1'b0, 1'b0, 32'h0, 1'b0);
    #1 chk("mp_spec_101", 32'(bus.addr), 32'h005);
    set_fetch(1'b1, 1'b1, 32'h0, 1'b1);
    set_res(1'b1, 1'b1, 1'b1);
    tick();
    set_fetch(1'b0, 1'b0, 32'h0, 1'b0);
    set_res(1'b0, 1'b0, 1'b0);
    #1;
    chk("mp_past", 32'(bus.past), 32'h000);
    chk("mp_taken2", 32'(bus.taken2), 32'h1);
    chk("mp_upd", 32'(bus.upd_valid), 32'h1);
    chk("mp_repair", 32'(bus.addr), 32'h001);
    chk("mp_full", 32'(bus.full), 32'h0);
    set_res(1'b1, 1'b1, 1'b0);
    tick();
    chk("empty_upd", 32'(bus.upd_valid), 32'h0);
    chk("empty_err", 32'(bus.resolve_err), 32'h1);
    chk("empty_past_held", 32'(bus.past), 32'h000);
    set_res(1'b0, 1'b0, 1'b0);
    tick();
    chk("err_sticky", 32'(bus.resolve_err), 32'h1);
    chk("empty_hist_kept", 32'(bus.addr), 32'h001);

    // Reset mid-operation with three entries queued and a resolve pending
    for (int i = 0; i < 4; i++) begin
      set_fetch(1'b1, 1'b1, 32'h100, 1'b1);
      tick();
    end
    set_fetch(1'b0, 1'b0, 32'h100, 1'b0);
    set_res(1'b1, 1'b1, 1'b0);
    tick();
    chk("pre_rst_past", 32'(bus.past), 32'h041);
    chk("pre_rst_taken2", 32'(bus.taken2), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_res(1'b0, 1'b0, 1'b0);
    set_fetch(1'b0, 1'b0, 32'h1234, 1'b0);
    #1;
    chk("mid_rst_upd", 32'(bus.upd_valid), 32'h0);
    chk("mid_rst_past", 32'(bus.past), 32'h0);
    chk("mid_rst_taken2", 32'(bus.taken2), 32'h0);
    chk("mid_rst_err", 32'(bus.resolve_err), 32'h0);
    chk("mid_rst_full", 32'(bus.full), 32'h0);
    chk("mid_rst_addr", 32'(bus.addr), 32'h48D);
    set_res(1'b1, 1'b0, 1'b0);
    tick();
    chk("post_rst_empty_upd", 32'(bus.upd_valid), 32'h0);
    chk("post_rst_empty_err", 32'(bus.resolve_err), 32'h1);
    set_res(1'b0, 1'b0, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
